// File: rtl/pc_sequencer_pkg.sv
// Shared CPU-core definitions used by the PC sequencer: word size, FSM states and
// next-PC select codes.
package pc_sequencer_pkg;

    localparam int unsigned CPU_WORD_SIZE = 16;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StExec,
        StHalt
    } pc_state_e;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_SEQ,
        SEL_REL,
        SEL_ABS,
        SEL_RET
    } pc_sel_e;

endpackage

// File: rtl/pc_ras_stack.sv
// Return-address LIFO for the PC sequencer: push when not full, pop when not empty.
// The caller is expected never to push and pop in the same cycle.
module pc_ras_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_push_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [AW-1:0]    w_top_idx;
    logic [AW-1:0]    w_wr_idx;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_top_idx = AW'(r_count - CW'(1));
    assign w_wr_idx  = AW'(r_count);
    assign o_top     = o_empty ? '0 : r_mem[w_top_idx];
    assign w_do_push = i_push && !o_full && !i_pop;
    assign w_do_pop  = i_pop && !o_empty && !i_push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_do_push) begin
            r_count <= r_count + CW'(1);
        end else if (w_do_pop) begin
            r_count <= r_count - CW'(1);
        end
    end

    // Entries need no reset: only r_count decides what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= i_push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch/execute handshake and next-PC selection driving the
// pointer register. Optional return-address stack enabled by defining PC_SEQ_RAS_EN.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = CPU_WORD_SIZE,
    parameter int unsigned RESET_VECTOR = 0,
    parameter int          INC          = 1,
    parameter int unsigned RAS_DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 halt_req,
    output logic                 imem_req,
    input  logic                 imem_ack,
    input  logic                 instr_done,
    input  logic                 br_valid,
    input  logic                 br_abs,
    input  logic [WORD_SIZE-1:0] br_val,
    input  logic                 call,
    input  logic                 ret,
    input  logic [WORD_SIZE-1:0] ptr_out,
    output logic [WORD_SIZE-1:0] ptr_val,
    output logic                 ptr_set,
    output logic                 ptr_update,
    output logic                 busy,
    output logic                 halted,
    output logic                 ras_err
);

    localparam logic [WORD_SIZE-1:0] RST_VEC = WORD_SIZE'(RESET_VECTOR);
    localparam logic [WORD_SIZE-1:0] INC_VAL = WORD_SIZE'(INC);

    pc_state_e            r_state;
    logic                 r_imem_req;
    logic                 r_busy;
    logic                 r_halted;
    logic                 r_halt_pend;
    logic                 w_start;
    logic                 w_retire;
    logic                 w_halt;
    logic                 w_pop;
    logic                 w_ras_empty;
    logic [WORD_SIZE-1:0] w_ras_top;
    pc_sel_e              w_sel;

    assign w_start  = start && ((r_state == StIdle) || (r_state == StHalt));
    assign w_retire = (r_state == StExec) && instr_done;
    assign w_halt   = halt_req || r_halt_pend;

`ifdef PC_SEQ_RAS_EN
    logic w_push;
    logic w_ras_full;
    logic r_ras_err;

    // A simultaneous ret takes priority, so the call's push is suppressed.
    assign w_pop  = w_retire && ret;
    assign w_push = w_retire && call && br_valid && !ret;

    pc_ras_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (WORD_SIZE)
    ) u_ras (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (ptr_out + INC_VAL),
        .o_top       (w_ras_top),
        .o_full      (w_ras_full),
        .o_empty     (w_ras_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ras_err <= 1'b0;
        end else if ((w_push && w_ras_full) || (w_pop && w_ras_empty)) begin
            r_ras_err <= 1'b1;
        end
    end

    assign ras_err = r_ras_err;
`else
    logic w_unused_ras;

    assign w_pop        = 1'b0;
    assign w_ras_empty  = 1'b1;
    assign w_ras_top    = '0;
    assign ras_err      = 1'b0;
    assign w_unused_ras = ^{call, ret, ptr_out, (RAS_DEPTH != 0)};
`endif

    always_comb begin
        w_sel = SEL_NONE;
        if (w_retire) begin
            if (w_pop) begin
                w_sel = SEL_RET;
            end else if (br_valid && br_abs) begin
                w_sel = SEL_ABS;
            end else if (br_valid) begin
                w_sel = SEL_REL;
            end else begin
                w_sel = SEL_SEQ;
            end
        end
    end

    always_comb begin
        ptr_set    = 1'b0;
        ptr_update = 1'b0;
        ptr_val    = '0;
        if (w_start) begin
            ptr_set = 1'b1;
            ptr_val = RST_VEC;
        end else begin
            case (w_sel)
                SEL_RET: begin
                    ptr_set = 1'b1;
                    ptr_val = w_ras_empty ? RST_VEC : w_ras_top;
                end
                SEL_ABS: begin
                    ptr_set = 1'b1;
                    ptr_val = br_val;
                end
                SEL_REL: begin
                    ptr_update = 1'b1;
                    ptr_val    = br_val;
                end
                SEL_SEQ: begin
                    ptr_update = 1'b1;
                    ptr_val    = INC_VAL;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_imem_req  <= 1'b0;
            r_busy      <= 1'b0;
            r_halted    <= 1'b0;
            r_halt_pend <= 1'b0;
        end else begin
            case (r_state)
                StIdle, StHalt: begin
                    if (start) begin
                        r_state     <= StFetch;
                        r_imem_req  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_halted    <= 1'b0;
                        r_halt_pend <= 1'b0;
                    end
                end
                StFetch: begin
                    if (halt_req) begin
                        r_halt_pend <= 1'b1;
                    end
                    if (imem_ack) begin
                        r_state    <= StExec;
                        r_imem_req <= 1'b0;
                    end
                end
                StExec: begin
                    if (instr_done) begin
                        r_halt_pend <= 1'b0;
                        if (w_halt) begin
                            r_state  <= StHalt;
                            r_busy   <= 1'b0;
                            r_halted <= 1'b1;
                        end else begin
                            r_state    <= StFetch;
                            r_imem_req <= 1'b1;
                        end
                    end else if (halt_req) begin
                        r_halt_pend <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= StIdle;
                    r_imem_req <= 1'b0;
                    r_busy     <= 1'b0;
                    r_halted   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req = r_imem_req;
    assign busy     = r_busy;
    assign halted   = r_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: table of retire vectors plus hand-written sequences.
// Models the external pointer register; RAS checks are enabled with PC_SEQ_RAS_EN.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        halt_req;
    logic        imem_req;
    logic        imem_ack;
    logic        instr_done;
    logic        br_valid;
    logic        br_abs;
    logic [15:0] br_val;
    logic        call;
    logic        ret;
    logic [15:0] ptr_out;
    logic [15:0] ptr_val;
    logic        ptr_set;
    logic        ptr_update;
    logic        busy;
    logic        halted;
    logic        ras_err;

    logic        tb_load;
    logic [15:0] load_val;

    int n_cmp;
    int n_err;

    typedef struct {
        logic [15:0] pc;
        logic        bv;
        logic        ba;
        logic [15:0] bval;
        logic        c;
        logic        r;
        logic        es;
        logic        eu;
        logic [15:0] ev;
        logic [15:0] ep;
    } vec_t;

    vec_t vecs [10];
    int   n_vec;

    pc_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .halt_req   (halt_req),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .instr_done (instr_done),
        .br_valid   (br_valid),
        .br_abs     (br_abs),
        .br_val     (br_val),
        .call       (call),
        .ret        (ret),
        .ptr_out    (ptr_out),
        .ptr_val    (ptr_val),
        .ptr_set    (ptr_set),
        .ptr_update (ptr_update),
        .busy       (busy),
        .halted     (halted),
        .ras_err    (ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External pointer register; tb_load lets the bench place the PC anywhere.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_out <= 16'h0000;
        end else if (tb_load) begin
            ptr_out <= load_val;
        end else if (ptr_set) begin
            ptr_out <= ptr_val;
        end else if (ptr_update) begin
            ptr_out <= ptr_out + ptr_val;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no summary, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Entered in a FETCH cycle; leaves in the first EXEC cycle.
    task automatic do_fetch(input int d);
        for (int i = 0; i < d; i++) begin
            check("fetch_wait_req", imem_req, 1);
            cyc();
            #1;
        end
        imem_ack = 1'b1;
        #1;
        check("fetch_req", imem_req, 1);
        cyc();
        imem_ack = 1'b0;
        #1;
        check("exec_req", imem_req, 0);
        check("exec_busy", busy, 1);
    endtask

    task automatic load_pc(input logic [15:0] pc);
        tb_load  = 1'b1;
        load_val = pc;
        cyc();
        tb_load = 1'b0;
    endtask

    task automatic do_start();
        cyc();
        start = 1'b1;
        #1;
        check("start_set", ptr_set, 1);
        check("start_upd", ptr_update, 0);
        check("start_val", ptr_val, 16'h0000);
        cyc();
        start = 1'b0;
        #1;
        check("start_req", imem_req, 1);
        check("start_pc", ptr_out, 16'h0000);
        check("start_busy", busy, 1);
        check("start_halted", halted, 0);
        check("start_set_off", ptr_set, 0);
    endtask

    // Entered in an EXEC cycle; leaves in the following FETCH (or HALT) cycle.
    task automatic retire(input string tag, input logic bv, input logic ba,
                          input logic [15:0] bval, input logic c, input logic r,
                          input logic h, input logic es, input logic eu,
                          input logic [15:0] ev, input logic [15:0] ep, input logic eh);
        instr_done = 1'b1;
        br_valid   = bv;
        br_abs     = ba;
        br_val     = bval;
        call       = c;
        ret        = r;
        halt_req   = h;
        #1;
        check({tag, "_set"}, ptr_set, es);
        check({tag, "_upd"}, ptr_update, eu);
        check({tag, "_val"}, ptr_val, ev);
        cyc();
        instr_done = 1'b0;
        br_valid   = 1'b0;
        br_abs     = 1'b0;
        br_val     = 16'h0000;
        call       = 1'b0;
        ret        = 1'b0;
        halt_req   = 1'b0;
        #1;
        check({tag, "_pc"}, ptr_out, ep);
        check({tag, "_halted"}, halted, eh);
        check({tag, "_req"}, imem_req, !eh);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        halt_req   = 1'b0;
        imem_ack   = 1'b0;
        instr_done = 1'b0;
        br_valid   = 1'b0;
        br_abs     = 1'b0;
        br_val     = 16'h0000;
        call       = 1'b0;
        ret        = 1'b0;
        tb_load    = 1'b0;
        load_val   = 16'h0000;

        n_vec = 0;
        vecs[n_vec++] = '{16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h0001, 16'h0001};
        vecs[n_vec++] = '{16'h0005, 1, 0, 16'hFFFD, 0, 0, 0, 1, 16'hFFFD, 16'h0002};
        vecs[n_vec++] = '{16'hFFFF, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h0001, 16'h0000};
        vecs[n_vec++] = '{16'h0010, 1, 1, 16'h1234, 0, 0, 1, 0, 16'h1234, 16'h1234};
        vecs[n_vec++] = '{16'h0010, 1, 0, 16'h0100, 0, 0, 0, 1, 16'h0100, 16'h0110};
        vecs[n_vec++] = '{16'h8001, 1, 0, 16'h7FFF, 0, 0, 0, 1, 16'h7FFF, 16'h0000};
        vecs[n_vec++] = '{16'h0000, 1, 1, 16'hFFFF, 0, 0, 1, 0, 16'hFFFF, 16'hFFFF};
`ifndef PC_SEQ_RAS_EN
        vecs[n_vec++] = '{16'h0007, 0, 0, 16'h0000, 0, 1, 0, 1, 16'h0001, 16'h0008};
        vecs[n_vec++] = '{16'h0040, 1, 0, 16'h0010, 1, 0, 0, 1, 16'h0010, 16'h0050};
        vecs[n_vec++] = '{16'h0050, 1, 0, 16'h0004, 0, 1, 0, 1, 16'h0004, 16'h0054};
`endif

        // Reset state
        cyc();
        cyc();
        check("rst_req", imem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_ras_err", ras_err, 0);
        check("rst_set", ptr_set, 0);
        check("rst_upd", ptr_update, 0);
        rst_n = 1'b1;
        cyc();
        check("idle_req", imem_req, 0);

        do_start();

        // Three sequential retires with ack two cycles after each request
        for (int k = 0; k < 3; k++) begin
            do_fetch(2);
            check("seq_fetch_pc", ptr_out, 32'(k));
            retire("seq", 0, 0, 16'h0000, 0, 0, 0, 0, 1, 16'h0001, 16'(k + 1), 0);
        end

        for (int i = 0; i < n_vec; i++) begin
            do_fetch(i % 3);
            load_pc(vecs[i].pc);
            retire($sformatf("vec%0d", i), vecs[i].bv, vecs[i].ba, vecs[i].bval,
                   vecs[i].c, vecs[i].r, 0, vecs[i].es, vecs[i].eu, vecs[i].ev,
                   vecs[i].ep, 0);
        end

        // Absolute jump together with halt_req, then restart from HALT
        do_fetch(1);
        retire("abs_halt", 1, 1, 16'h0040, 0, 0, 1, 1, 0, 16'h0040, 16'h0040, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("halt_req_off", imem_req, 0);
            check("halt_busy", busy, 0);
            check("halt_hold_pc", ptr_out, 16'h0040);
        end
        do_start();

        // halt_req pulsed during FETCH is held until the instruction retires
        halt_req = 1'b1;
        #1;
        check("pend_req", imem_req, 1);
        cyc();
        halt_req = 1'b0;
        do_fetch(0);
        retire("pend_halt", 0, 0, 16'h0000, 0, 0, 0, 0, 1, 16'h0001, 16'h0001, 1);
        do_start();

        // start is ignored in FETCH and EXEC
        start = 1'b1;
        #1;
        check("start_in_fetch", ptr_set, 0);
        cyc();
        start = 1'b0;
        #1;
        check("start_in_fetch_pc", ptr_out, 16'h0000);
        do_fetch(0);
        start = 1'b1;
        #1;
        check("start_in_exec", ptr_set, 0);
        cyc();
        start = 1'b0;
        #1;
        check("start_in_exec_req", imem_req, 0);
        check("start_in_exec_busy", busy, 1);
        retire("after_start", 0, 0, 16'h0000, 0, 0, 0, 0, 1, 16'h0001, 16'h0001, 0);

`ifdef PC_SEQ_RAS_EN
        do_fetch(0);
        load_pc(16'h0008);
        retire("ras_call", 1, 1, 16'h0020, 1, 0, 0, 1, 0, 16'h0020, 16'h0020, 0);
        do_fetch(1);
        retire("ras_ret", 0, 0, 16'h0000, 0, 1, 0, 1, 0, 16'h0009, 16'h0009, 0);
        check("ras_err_ok", ras_err, 0);
        for (int i = 0; i < 5; i++) begin
            do_fetch(0);
            load_pc(16'(16'h0100 + i));
            retire("ras_nest", 1, 1, 16'(16'h0200 + i), 1, 0, 0, 1, 0,
                   16'(16'h0200 + i), 16'(16'h0200 + i), 0);
            check("ras_ovf", ras_err, (i == 4) ? 1 : 0);
        end
        do_fetch(0);
        retire("ras_pop1", 0, 0, 16'h0000, 0, 1, 0, 1, 0, 16'h0104, 16'h0104, 0);
        do_fetch(0);
        retire("ras_callret", 1, 1, 16'h0300, 1, 1, 0, 1, 0, 16'h0103, 16'h0103, 0);
        do_fetch(0);
        retire("ras_pop3", 0, 0, 16'h0000, 0, 1, 0, 1, 0, 16'h0102, 16'h0102, 0);
        do_fetch(0);
        retire("ras_pop4", 0, 0, 16'h0000, 0, 1, 0, 1, 0, 16'h0101, 16'h0101, 0);
        do_fetch(0);
        retire("ras_empty", 0, 0, 16'h0000, 0, 1, 0, 1, 0, 16'h0000, 16'h0000, 0);
        check("ras_err_sticky", ras_err, 1);
`endif

        // Reset in the middle of a fetch
        check("mid_req", imem_req, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", imem_req, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ras_err", ras_err, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        imem_ack = 1'b1;
        #1;
        check("late_ack_set", ptr_set, 0);
        cyc();
        imem_ack = 1'b0;
        #1;
        check("late_ack_req", imem_req, 0);
        check("late_ack_busy", busy, 0);
        cyc();
        check("late_ack_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
